sr_bank_ctrl: RTL and testbench

Sequencing controller and two-port arbiter for a bank of N clocked SR flip-flops (the SR-from-JK cells, ports s/r/q/qbar). Two requesters issue read/set/clear/toggle commands on one bit each; the block grants one at a time round-robin, drives the selected cell's s or r for exactly one clock, checks the q/qbar feedback, and returns an ack carrying the bit value and an error flag. It is the only driver of the bank's s/r inputs and guarantees the forbidden s=r=1 input is never applied.

---
 rtl/sr_bank_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_sr_bank_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_bank_ctrl.sv
// Round-robin two-port controller for a bank of clocked SR cells; drives s/r one-hot for one cycle and checks q/qbar.
// Optional feedback check stage: define SR_BANK_CTRL_CHECK_EN to include the CHECK state and err reporting.
//
//   state | meaning
//   IDLE  | waiting for req0/req1; winner picked round-robin
//   GRANT | winner's op/idx latched, expected value formed from q[idx]
//   DRIVE | single-cycle s or r pulse on the selected cell
//   CHECK | compare q/qbar against expectation, bounded by CHK_MAX
//   DONE  | ack pulse on the granted port, last_grant updated

module sr_bank_ctrl #(
    parameter int IDXW    = 3,
    parameter int CHK_MAX = 3,
    localparam int N      = 2 ** IDXW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0,
    input  logic            req1,
    input  logic [1:0]      op0,
    input  logic [1:0]      op1,
    input  logic [IDXW-1:0] idx0,
    input  logic [IDXW-1:0] idx1,
    output logic            ack0,
    output logic            ack1,
    output logic            rdata,
    output logic            err,
    output logic            busy,
    output logic [N-1:0]    s,
    output logic [N-1:0]    r,
    input  logic [N-1:0]    q,
    input  logic [N-1:0]    qbar
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GRANT = 3'd1,
        DRIVE = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [1:0] OP_READ   = 2'b00;
    localparam logic [1:0] OP_SET    = 2'b01;
    localparam logic [1:0] OP_CLEAR  = 2'b10;
    localparam logic [1:0] OP_TOGGLE = 2'b11;

    state_t          state_q, state_d;
    logic            last_grant_q, last_grant_d;
    logic            gnt_q, gnt_d;
    logic [1:0]      op_q, op_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [N-1:0]    s_q, s_d;
    logic [N-1:0]    r_q, r_d;
    logic            ack0_q, ack0_d;
    logic            ack1_q, ack1_d;
    logic            busy_q, busy_d;
    logic            q_sel;

    assign q_sel = q[idx_q];

`ifdef SR_BANK_CTRL_CHECK_EN
    localparam int CNTW = (CHK_MAX > 1) ? $clog2(CHK_MAX) : 1;

    logic            exp_q, exp_d;
    logic [CNTW-1:0] chk_cnt_q, chk_cnt_d;
    logic            rdata_q, rdata_d;
    logic            err_q, err_d;
    logic            pass;

    assign pass = (q_sel == exp_q) && (qbar[idx_q] == ~q_sel);
`else
    logic unused_fb;
    assign unused_fb = ^{qbar, (CHK_MAX > 0)};
`endif

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        gnt_d        = gnt_q;
        op_d         = op_q;
        idx_d        = idx_q;
        s_d          = '0;
        r_d          = '0;
`ifdef SR_BANK_CTRL_CHECK_EN
        exp_d        = exp_q;
        chk_cnt_d    = chk_cnt_q;
        rdata_d      = 1'b0;
        err_d        = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    gnt_d   = (req0 && req1) ? ~last_grant_q : req1;
                    op_d    = gnt_d ? op1 : op0;
                    idx_d   = gnt_d ? idx1 : idx0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
`ifdef SR_BANK_CTRL_CHECK_EN
                chk_cnt_d = '0;
                case (op_q)
                    OP_READ:  exp_d = q_sel;
                    OP_SET:   exp_d = 1'b1;
                    OP_CLEAR: exp_d = 1'b0;
                    default:  exp_d = ~q_sel;
                endcase
`endif
                // s/r registered here so the pulse lands exactly in DRIVE
                case (op_q)
                    OP_SET:    s_d[idx_q] = 1'b1;
                    OP_CLEAR:  r_d[idx_q] = 1'b1;
                    OP_TOGGLE: begin
                        if (q_sel) r_d[idx_q] = 1'b1;
                        else       s_d[idx_q] = 1'b1;
                    end
                    default: ;
                endcase
`ifdef SR_BANK_CTRL_CHECK_EN
                state_d = (op_q == OP_READ) ? CHECK : DRIVE;
`else
                state_d = (op_q == OP_READ) ? DONE : DRIVE;
`endif
            end
            DRIVE: begin
`ifdef SR_BANK_CTRL_CHECK_EN
                state_d = CHECK;
`else
                state_d = DONE;
`endif
            end
`ifdef SR_BANK_CTRL_CHECK_EN
            CHECK: begin
                if (pass) begin
                    state_d = DONE;
                    rdata_d = q_sel;
                end else if (chk_cnt_q == CNTW'(CHK_MAX - 1)) begin
                    state_d = DONE;
                    rdata_d = q_sel;
                    err_d   = 1'b1;
                end else begin
                    chk_cnt_d = chk_cnt_q + CNTW'(1);
                end
            end
`endif
            DONE: begin
                last_grant_d = gnt_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase

        ack0_d = (state_d == DONE) && !gnt_q;
        ack1_d = (state_d == DONE) &&  gnt_q;
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            gnt_q        <= 1'b0;
            op_q         <= OP_READ;
            idx_q        <= '0;
            s_q          <= '0;
            r_q          <= '0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            gnt_q        <= gnt_d;
            op_q         <= op_d;
            idx_q        <= idx_d;
            s_q          <= s_d;
            r_q          <= r_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            busy_q       <= busy_d;
        end
    end

`ifdef SR_BANK_CTRL_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            exp_q     <= 1'b0;
            chk_cnt_q <= '0;
            rdata_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            exp_q     <= exp_d;
            chk_cnt_q <= chk_cnt_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

    assign rdata = rdata_q;
    assign err   = err_q;
`else
    // Without a CHECK cycle the post-write value only exists during DONE, so
    // rdata follows the bank's own registered q for that one cycle.
    assign rdata = (state_q == DONE) && q_sel;
    assign err   = 1'b0;
`endif

    assign s    = s_q;
    assign r    = r_q;
    assign ack0 = ack0_q;
    assign ack1 = ack1_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_sr_bank_ctrl.sv
// Bench for sr_bank_ctrl: SR bank plant, abstract bit-value/arbitration model, directed and random commands.
// Expectations follow SR_BANK_CTRL_CHECK_EN when it is defined for the build.

module tb_sr_bank_ctrl;
    localparam int IDXW    = 3;
    localparam int N       = 8;
    localparam int CHK_MAX = 3;
`ifdef SR_BANK_CTRL_CHECK_EN
    localparam bit CHK_ON = 1'b1;
`else
    localparam bit CHK_ON = 1'b0;
`endif
    localparam int WLAT  = CHK_ON ? 4 : 3;
    localparam int RLAT  = CHK_ON ? 3 : 2;
    localparam int FLAT  = CHK_ON ? 3 + CHK_MAX : 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            req0, req1;
    logic [1:0]      op0, op1;
    logic [IDXW-1:0] idx0, idx1;
    logic            ack0, ack1, rdata, err, busy;
    logic [N-1:0]    s, r, q, qbar;

    logic [N-1:0]    bank, init_val, fq_mask, fq_val, fqb_mask;
    logic            load;

    int checks = 0;
    int errors = 0;
    bit mdl [N];
    bit mdl_last;

    sr_bank_ctrl #(.IDXW(IDXW), .CHK_MAX(CHK_MAX)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .op0(op0), .op1(op1), .idx0(idx0), .idx1(idx1),
        .ack0(ack0), .ack1(ack1), .rdata(rdata), .err(err), .busy(busy),
        .s(s), .r(r), .q(q), .qbar(qbar)
    );

    always #5 clk = ~clk;

    // SR bank plant: each cell captures its s/r on the shared clock
    always @(posedge clk) begin
        if (load) bank <= init_val;
        else      bank <= (bank | s) & ~r;
    end

    assign q    = (bank & ~fq_mask) | (fq_val & fq_mask);
    assign qbar = (~bank & ~fqb_mask) | (q & fqb_mask);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("sr_overlap", 32'(s & r), 32'd0);
        chk("sr_onehot", 32'($countones(s | r) <= 1), 32'd1);
    end

    function automatic bit apply_op(input logic [1:0] op, input bit cur);
        case (op)
            2'd0:    return cur;
            2'd1:    return 1'b1;
            2'd2:    return 1'b0;
            default: return ~cur;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits from the IDLE cycle (cycle 0) to the next ack, then steps into the following IDLE cycle.
    task automatic cmd_wait(output int port, output int lat, output logic rd, output logic er,
                            output int nsr, output int srcyc, output logic [N-1:0] sv,
                            output logic [N-1:0] rv, output logic b0);
        int n = -1;
        port = -1; lat = -1; rd = 1'b0; er = 1'b0;
        nsr = 0; srcyc = -1; sv = '0; rv = '0; b0 = 1'b1;
        while (lat < 0 && n < 30) begin
            @(negedge clk);
            n++;
            if (n == 0) b0 = busy;
            if ((s | r) != '0) begin
                nsr++;
                srcyc = n;
                sv = s;
                rv = r;
            end
            if (ack0 || ack1) begin
                port = (ack0 && ack1) ? 2 : (ack1 ? 1 : 0);
                lat  = n;
                rd   = rdata;
                er   = err;
            end
        end
        step();
    endtask

    task automatic expect_cmd(input string tag, input int p, input logic [1:0] op, input logic [IDXW-1:0] idx);
        bit cur, res;
        logic [N-1:0] es, ers, sv, rv;
        int port, lat, nsr, srcyc;
        logic rd, er, b0;
        cur = mdl[idx];
        res = apply_op(op, cur);
        es  = (op == 2'd1 || (op == 2'd3 && !cur)) ? N'(1 << idx) : '0;
        ers = (op == 2'd2 || (op == 2'd3 &&  cur)) ? N'(1 << idx) : '0;
        cmd_wait(port, lat, rd, er, nsr, srcyc, sv, rv, b0);
        chk({tag, "_port"},  port, p);
        chk({tag, "_lat"},   lat, (op == 2'd0) ? RLAT : WLAT);
        chk({tag, "_rdata"}, 32'(rd), 32'(res));
        chk({tag, "_err"},   32'(er), 32'd0);
        chk({tag, "_nsr"},   nsr, (op == 2'd0) ? 0 : 1);
        chk({tag, "_srcyc"}, srcyc, (op == 2'd0) ? -1 : 2);
        chk({tag, "_s"},     32'(sv), 32'(es));
        chk({tag, "_r"},     32'(rv), 32'(ers));
        chk({tag, "_busy0"}, 32'(b0), 32'd0);
        mdl[idx] = res;
        mdl_last = p[0];
    endtask

    initial begin
        int port, lat, nsr, srcyc, w, mode, acks;
        logic rd, er, b0;
        logic [N-1:0] sv, rv, mdl_vec;

        init_val = N'($urandom);
        foreach (mdl[i]) mdl[i] = init_val[i];
        load = 1'b1; fq_mask = '0; fq_val = '0; fqb_mask = '0;
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; op0 = '0; op1 = '0; idx0 = '0; idx1 = '0;
        step(); step();
        rst = 1'b0; load = 1'b0;
        mdl_last = 1'b1;
        @(negedge clk);
        chk("reset_outs", 32'({s, r, ack0, ack1, rdata, err, busy}), 32'd0);
        step();

        // set, toggle and read of bit 5
        req0 = 1'b1; op0 = 2'd1; idx0 = 3'd5;
        expect_cmd("set5", 0, op0, idx0);
        op0 = 2'd3;
        expect_cmd("tog5", 0, op0, idx0);
        op0 = 2'd0;
        expect_cmd("rd5", 0, op0, idx0);
        req0 = 1'b0;
        req1 = 1'b1; op1 = 2'd0; idx1 = 3'd0;
        expect_cmd("rd0_p1", 1, op1, idx1);
        req1 = 1'b0;

        // both held: grants alternate on each IDLE visit
        op0 = 2'd3; idx0 = 3'd1; op1 = 2'd3; idx1 = 3'd6;
        req0 = 1'b1; req1 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            w = mdl_last ? 0 : 1;
            expect_cmd("arb", w, w ? op1 : op0, w ? idx1 : idx0);
        end
        req0 = 1'b0; req1 = 1'b0;

        // q[2] stuck low during a set of bit 2
        fq_mask = 8'h04; fq_val = 8'h00;
        req0 = 1'b1; op0 = 2'd1; idx0 = 3'd2;
        cmd_wait(port, lat, rd, er, nsr, srcyc, sv, rv, b0);
        req0 = 1'b0; fq_mask = '0;
        chk("fq_port", port, 0);
        chk("fq_lat", lat, FLAT);
        chk("fq_err", 32'(er), 32'(CHK_ON));
        chk("fq_rdata", 32'(rd), 32'd0);
        mdl[2] = 1'b1; mdl_last = 1'b0;

        // qbar[2] equal to q[2] during a set of bit 2
        fqb_mask = 8'h04;
        req0 = 1'b1;
        cmd_wait(port, lat, rd, er, nsr, srcyc, sv, rv, b0);
        req0 = 1'b0; fqb_mask = '0;
        chk("fqb_lat", lat, FLAT);
        chk("fqb_err", 32'(er), 32'(CHK_ON));
        chk("fqb_rdata", 32'(rd), 32'd1);
        mdl_last = 1'b0;

        // reset while DRIVE is active: request dropped, no ack
        req0 = 1'b1; op0 = 2'd1; idx0 = 3'd3;
        @(negedge clk);
        @(negedge clk);
        step();
        rst = 1'b1; req0 = 1'b0;
        @(negedge clk);
        chk("rstmid_drive_s", 32'(s), 32'h08);
        step();
        rst = 1'b0;
        mdl[3] = 1'b1; mdl_last = 1'b1;
        @(negedge clk);
        chk("rstmid_outs", 32'({s, r, busy, ack0, ack1}), 32'd0);
        acks = 0;
        repeat (6) begin
            @(negedge clk);
            if (ack0 || ack1) acks++;
        end
        chk("rstmid_noack", acks, 0);
        step();

        // tie right after reset goes to req0; after a port-0 grant a tie goes to req1
        req0 = 1'b1; req1 = 1'b1; op0 = 2'd0; idx0 = 3'd3; op1 = 2'd0; idx1 = 3'd4;
        expect_cmd("tie_after_rst", mdl_last ? 0 : 1, op0, idx0);
        req0 = 1'b0; req1 = 1'b0;
        req0 = 1'b1; req1 = 1'b1; op0 = 2'd2; idx0 = 3'd7; op1 = 2'd1; idx1 = 3'd7;
        expect_cmd("tie_last0", mdl_last ? 0 : 1, op1, idx1);
        req0 = 1'b0; req1 = 1'b0;

        repeat (40) begin
            mode = int'($urandom_range(0, 2));
            op0 = 2'($urandom); op1 = 2'($urandom);
            idx0 = 3'($urandom); idx1 = 3'($urandom);
            if (mode == 2) begin
                req0 = 1'b1; req1 = 1'b1;
                w = mdl_last ? 0 : 1;
                expect_cmd("rnd_tie_a", w, w ? op1 : op0, w ? idx1 : idx0);
                if (w == 0) req0 = 1'b0; else req1 = 1'b0;
                expect_cmd("rnd_tie_b", 1 - w, w ? op0 : op1, w ? idx0 : idx1);
                req0 = 1'b0; req1 = 1'b0;
            end else if (mode == 1) begin
                req1 = 1'b1;
                expect_cmd("rnd_p1", 1, op1, idx1);
                req1 = 1'b0;
            end else begin
                req0 = 1'b1;
                expect_cmd("rnd_p0", 0, op0, idx0);
                req0 = 1'b0;
            end
        end

        foreach (mdl[i]) mdl_vec[i] = mdl[i];
        @(negedge clk);
        chk("bank_final", 32'(bank), 32'(mdl_vec));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
